ntm_matrix_adder: RTL and testbench

Streaming element-wise matrix adder/subtractor for the NTM arithmetic library. It generalises the registered scalar adder to SIZE_I x SIZE_J matrices of signed DATA_WIDTH elements. Per-element valid/ready handshakes, add/sub mode, overflow detection and optional saturation are included. It sits between the NTM controller's operand streams and the result memory.

---
 rtl/ntm_matrix_adder.sv | 154 +++++++++++++++
 tb/tb_ntm_matrix_adder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntm_matrix_adder.sv
// ntm_matrix_adder
// ----------------
// Streaming element-wise adder/subtractor for SIZE_I x SIZE_J matrices of
// signed DATA_WIDTH elements. A and B arrive as row-major operand pairs.
// Each result is registered one cycle after its operands are accepted, and
// is tagged with its row/column index.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start, mode           begin an operation (IDLE only); 0 = A+B, 1 = A-B
//   in_valid, in_ready    operand handshake
//   data_a_in, data_b_in  operand elements (signed)
//   out_valid, out_ready  result handshake (single-stage output register)
//   data_out              result element (wrapped or saturated on overflow)
//   index_i, index_j      row/column of data_out
//   out_last              data_out is the final element of the matrix
//   busy                  operation in progress (RUN or DRAIN)
//   done                  one-cycle pulse after the last result is taken
//   overflow              sticky overflow flag for the current/last operation
module ntm_matrix_adder #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE_I     = 4,
    parameter int SIZE_J     = 4,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        mode,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [DATA_WIDTH-1:0]                       data_a_in,
    input  logic [DATA_WIDTH-1:0]                       data_b_in,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [DATA_WIDTH-1:0]                       data_out,
    output logic [((SIZE_I > 1) ? $clog2(SIZE_I) : 1)-1:0] index_i,
    output logic [((SIZE_J > 1) ? $clog2(SIZE_J) : 1)-1:0] index_j,
    output logic                                        out_last,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        overflow
);

    localparam int IW = (SIZE_I > 1) ? $clog2(SIZE_I) : 1;
    localparam int JW = (SIZE_J > 1) ? $clog2(SIZE_J) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(SIZE_I - 1);
    localparam logic [JW-1:0] J_LAST = JW'(SIZE_J - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_next;

    logic [IW-1:0]         cnt_i;
    logic [JW-1:0]         cnt_j;
    logic                  mode_q;
    logic                  in_xfer;
    logic                  out_xfer;
    logic                  last_elem;
    logic signed [DATA_WIDTH:0] a_ext, b_ext, sum_ext;
    logic                  elem_ovf;
    logic [DATA_WIDTH-1:0] result;

    // The output register is a single stage, so new operands can only be
    // taken when it is empty or being emptied on this same edge.
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign last_elem = (cnt_i == I_LAST) && (cnt_j == J_LAST);
    assign busy      = (state != IDLE);

    // One extra bit of headroom makes the exact sum representable; overflow
    // is then simply the top two bits disagreeing.
    always_comb begin
        a_ext    = {data_a_in[DATA_WIDTH-1], data_a_in};
        b_ext    = {data_b_in[DATA_WIDTH-1], data_b_in};
        sum_ext  = mode_q ? (a_ext - b_ext) : (a_ext + b_ext);
        elem_ovf = sum_ext[DATA_WIDTH] ^ sum_ext[DATA_WIDTH-1];
        result   = sum_ext[DATA_WIDTH-1:0];
        if (SATURATE && elem_ovf) begin
            result = sum_ext[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN waits for the last result to leave the output register, so done
    // always follows the final handshake rather than the final input.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (in_xfer && last_elem) state_next = DRAIN;
            DRAIN:   if (out_xfer && out_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_i     <= '0;
            cnt_j     <= '0;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            index_i   <= '0;
            index_j   <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= (state == DRAIN) && out_xfer && out_last;

            if ((state == IDLE) && start) begin
                mode_q   <= mode;
                cnt_i    <= '0;
                cnt_j    <= '0;
                overflow <= 1'b0;
            end

            // A new result replaces the one being taken on the same edge,
            // giving back-to-back throughput without a bubble.
            if (in_xfer) begin
                out_valid <= 1'b1;
                data_out  <= result;
                index_i   <= cnt_i;
                index_j   <= cnt_j;
                out_last  <= last_elem;
                overflow  <= overflow | elem_ovf;
                if (cnt_j == J_LAST) begin
                    cnt_j <= '0;
                    cnt_i <= (cnt_i == I_LAST) ? '0 : cnt_i + 1'b1;
                end else begin
                    cnt_j <= cnt_j + 1'b1;
                end
            end else if (out_xfer) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ntm_matrix_adder.sv
// Testbench for ntm_matrix_adder: a wrapping and a saturating instance (2x2,
// 8-bit) share the same stimulus. Expected results are pushed to a queue as
// operands are accepted and compared while they sit on the output.
module tb_ntm_matrix_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] data_a_in = '0;
    logic [7:0] data_b_in = '0;

    logic       w_in_ready, w_out_valid, w_out_last, w_busy, w_done, w_overflow;
    logic [7:0] w_data_out;
    logic       w_index_i, w_index_j;
    logic       s_in_ready, s_out_valid, s_out_last, s_busy, s_done, s_overflow;
    logic [7:0] s_data_out;
    logic       s_index_i, s_index_j;

    always #5 clk = ~clk;

    ntm_matrix_adder #(.DATA_WIDTH(8), .SIZE_I(2), .SIZE_J(2), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(w_in_ready),
        .data_a_in(data_a_in), .data_b_in(data_b_in),
        .out_valid(w_out_valid), .out_ready(out_ready), .data_out(w_data_out),
        .index_i(w_index_i), .index_j(w_index_j), .out_last(w_out_last),
        .busy(w_busy), .done(w_done), .overflow(w_overflow)
    );

    ntm_matrix_adder #(.DATA_WIDTH(8), .SIZE_I(2), .SIZE_J(2), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .data_a_in(data_a_in), .data_b_in(data_b_in),
        .out_valid(s_out_valid), .out_ready(out_ready), .data_out(s_data_out),
        .index_i(s_index_i), .index_j(s_index_j), .out_last(s_out_last),
        .busy(s_busy), .done(s_done), .overflow(s_overflow)
    );

    typedef struct {
        logic [7:0] wrap;
        logic [7:0] sat;
        int         i;
        int         j;
        logic       last;
    } exp_t;

    exp_t sb[$];

    int   total_checks = 0;
    int   pass_checks  = 0;
    int   model_state  = 0;   // 0 idle, 1 run, 2 drain
    int   cnt_i = 0;
    int   cnt_j = 0;
    int   n_in = 0;
    int   done_seen = 0;
    logic model_mode = 1'b0;
    logic exp_ovf = 1'b0;
    logic exp_done = 1'b0;
    logic [7:0] va[4];
    logic [7:0] vb[4];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected) begin
            pass_checks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Independent reference arithmetic using plain integers.
    function automatic void calc(input logic [7:0] a, input logic [7:0] b, input logic m,
                                 output logic [7:0] w, output logic [7:0] s, output logic ov);
        int r;
        r  = m ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        ov = (r > 127) || (r < -128);
        w  = r[7:0];
        s  = (r > 127) ? 8'h7F : ((r < -128) ? 8'h80 : r[7:0]);
    endfunction

    // One clock cycle: drive inputs, check against the model, advance model.
    task automatic applyStimulus(input logic st, input logic m, input logic iv, input logic ordy,
                                 input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        logic ir_exp, in_x, out_x, done_now, ov;
        int   st0;
        start = st; mode = m; in_valid = iv; out_ready = ordy;
        data_a_in = a; data_b_in = b;
        #1;
        st0    = model_state;
        ir_exp = (model_state == 1) && ((sb.size() == 0) || ordy);
        checkOutput("busy", w_busy, (model_state != 0));
        checkOutput("in_ready_w", w_in_ready, ir_exp);
        checkOutput("in_ready_s", s_in_ready, ir_exp);
        checkOutput("out_valid_w", w_out_valid, (sb.size() != 0));
        checkOutput("out_valid_s", s_out_valid, (sb.size() != 0));
        checkOutput("done", w_done, exp_done);
        checkOutput("overflow_w", w_overflow, exp_ovf);
        checkOutput("overflow_s", s_overflow, exp_ovf);
        if (w_done) done_seen++;
        if (sb.size() != 0) begin
            e = sb[0];
            checkOutput("data_wrap", w_data_out, e.wrap);
            checkOutput("data_sat", s_data_out, e.sat);
            checkOutput("index_i", w_index_i, e.i);
            checkOutput("index_j", w_index_j, e.j);
            checkOutput("out_last", w_out_last, e.last);
        end
        out_x    = (sb.size() != 0) && ordy;
        in_x     = iv && ir_exp;
        done_now = 1'b0;
        if (out_x) begin
            e = sb.pop_front();
            if (e.last && (model_state == 2)) begin
                model_state = 0;
                done_now    = 1'b1;
            end
        end
        if (in_x) begin
            calc(a, b, model_mode, e.wrap, e.sat, ov);
            e.i = cnt_i; e.j = cnt_j;
            e.last = (cnt_i == 1) && (cnt_j == 1);
            sb.push_back(e);
            exp_ovf = exp_ovf | ov;
            n_in++;
            if (e.last) model_state = 2;
            if (cnt_j == 1) begin
                cnt_j = 0;
                cnt_i = (cnt_i == 1) ? 0 : cnt_i + 1;
            end else begin
                cnt_j++;
            end
        end
        if ((st0 == 0) && st) begin
            model_state = 1;
            model_mode  = m;
            cnt_i = 0; cnt_j = 0;
            exp_ovf = 1'b0;
        end
        exp_done = done_now;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        model_state = 0; cnt_i = 0; cnt_j = 0; n_in = 0;
        model_mode = 1'b0; exp_ovf = 1'b0; exp_done = 1'b0;
        #1;
        checkOutput("rst_out_valid", w_out_valid, 0);
        checkOutput("rst_data_w", w_data_out, 0);
        checkOutput("rst_data_s", s_data_out, 0);
        checkOutput("rst_index_i", w_index_i, 0);
        checkOutput("rst_index_j", w_index_j, 0);
        checkOutput("rst_out_last", w_out_last, 0);
        checkOutput("rst_busy", w_busy, 0);
        checkOutput("rst_done", w_done, 0);
        checkOutput("rst_overflow", w_overflow, 0);
        checkOutput("rst_in_ready", w_in_ready, 0);
    endtask

    // Run one matrix: start, stream operands, optionally stall the output
    // for 3 cycles and/or hold start high while busy. stop_after >= 0 quits
    // once that many operands have been accepted.
    task automatic runMatrix(input logic m, input int stall_at, input logic noise, input int stop_after);
        logic iv, ordy;
        n_in = 0;
        done_seen = 0;
        applyStimulus(1'b1, m, 1'b0, 1'b1, 8'h00, 8'h00);
        for (int c = 0; c < 100; c++) begin
            if (model_state == 0) break;
            if ((stop_after >= 0) && (n_in >= stop_after)) break;
            ordy = !((c >= stall_at) && (c < stall_at + 3));
            iv   = (model_state == 1) && (n_in < 4);
            applyStimulus(noise, noise ? ~m : m, iv, ordy,
                          (n_in < 4) ? va[n_in] : 8'h00, (n_in < 4) ? vb[n_in] : 8'h00);
        end
        if (stop_after < 0) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
            checkOutput("op_complete_busy", w_busy, 0);
            checkOutput("done_count", done_seen, 1);
        end
    endtask

    initial begin
        doReset();

        // Basic addition, continuous stream
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vb = '{8'd10, 8'd20, 8'd30, 8'd40};
        runMatrix(1'b0, 1000, 1'b0, -1);
        checkOutput("add_no_ovf", w_overflow, 0);

        // Subtraction including -128-1 and 127-(-1)
        va = '{8'd5, 8'h80, 8'd0, 8'd127};
        vb = '{8'd7, 8'd1, 8'd0, 8'hFF};
        runMatrix(1'b1, 1000, 1'b0, -1);
        checkOutput("sub_ovf_sticky", s_overflow, 1);

        // Addition overflow both directions with a 3-cycle output stall
        va = '{8'd100, 8'h9C, 8'd127, 8'h80};
        vb = '{8'd100, 8'h9C, 8'd1, 8'hFF};
        runMatrix(1'b0, 2, 1'b0, -1);
        checkOutput("add_ovf_sticky", w_overflow, 1);

        // New start clears overflow; start held high while busy is ignored
        va = '{8'd1, 8'd2, 8'd3, 8'd4};
        vb = '{8'd10, 8'd20, 8'd30, 8'd40};
        runMatrix(1'b0, 1000, 1'b1, -1);
        checkOutput("ovf_cleared", w_overflow, 0);

        // Reset mid-matrix, then a clean run from (0,0)
        va = '{8'd50, 8'hF6, 8'd7, 8'h81};
        vb = '{8'd3, 8'd20, 8'hF9, 8'd2};
        runMatrix(1'b1, 1000, 1'b0, 2);
        doReset();
        runMatrix(1'b1, 1, 1'b0, -1);

        $display("%0d/%0d checks passed", pass_checks, total_checks);
        $finish;
    end

endmodule
